// File: rtl/m_sequence_gen.sv
// Fibonacci LFSR sequence generator with word packing, valid/ready output
// slot with backpressure, and period measurement against the start state.
module m_sequence_gen #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h9C,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int unsigned      OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             bit_out,
  output logic [WIDTH-1:0] lfsr_state,
  output logic [OUT_W-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             period_pulse,
  output logic [WIDTH-1:0] period_len
);

  localparam int unsigned CW = (OUT_W > 2) ? $clog2(OUT_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OUT_W - 1);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] start;
  logic [OUT_W-1:0] pk;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sc;

  logic             fb;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] load_val;
  logic             at_last;
  logic             stall;
  logic             step;
  logic             complete;
  logic             wrap;

  assign bit_out    = s[WIDTH-1];
  assign lfsr_state = s;

  // Feedback, step qualification and word/period events for this cycle.
  always_comb begin
    fb       = ^(s & TAPS);
    s_next   = {s[WIDTH-2:0], fb};
    load_val = (seed_in == '0) ? SEED : seed_in;
    at_last  = (cnt == CNT_LAST);
    stall    = at_last & word_valid & ~word_ready;
    step     = en & ~load & ~stall;
    complete = step & at_last;
    wrap     = step & (s_next == start);
  end

  // LFSR state and the reference state used for period detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s     <= SEED;
      start <= SEED;
    end else if (load) begin
      s     <= load_val;
      start <= load_val;
    end else if (step) begin
      s <= s_next;
    end
  end

  // Serial-to-word packing; first emitted bit ends up in the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pk  <= '0;
      cnt <= '0;
    end else if (load) begin
      pk  <= '0;
      cnt <= '0;
    end else if (step) begin
      pk  <= {pk[OUT_W-2:0], bit_out};
      cnt <= at_last ? '0 : cnt + CW'(1);
    end
  end

  // Output slot: a completing step refills it even while it is being
  // drained, so back-to-back words carry no bubble; load discards it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_data  <= '0;
      word_valid <= 1'b0;
    end else if (load) begin
      word_valid <= 1'b0;
    end else if (complete) begin
      word_data  <= {pk[OUT_W-2:0], bit_out};
      word_valid <= 1'b1;
    end else if (word_valid && word_ready) begin
      word_valid <= 1'b0;
    end
  end

  // Saturating step counter; reports the period when the state wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc           <= '0;
      period_pulse <= 1'b0;
      period_len   <= '0;
    end else if (load) begin
      sc           <= '0;
      period_pulse <= 1'b0;
    end else if (wrap) begin
      sc           <= '0;
      period_pulse <= 1'b1;
      period_len   <= (sc == '1) ? sc : sc + WIDTH'(1);
    end else begin
      period_pulse <= 1'b0;
      if (step && (sc != '1)) sc <= sc + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_m_sequence_gen.sv
// Directed bench for m_sequence_gen: one instance with default taps
// (non-maximal, 17-state cycle through 0x01) and one with a maximal-length
// mask (0xB8, x^8+x^4+x^3+x^2+1) for the 255-step period checks.
module tb_m_sequence_gen;

  logic       clk;
  logic       rst_n;
  logic       en, load, word_ready;
  logic [7:0] seed_in;
  logic       bit_out, word_valid, period_pulse;
  logic [7:0] lfsr_state, word_data, period_len;

  logic       en_m, load_m, ready_m;
  logic [7:0] seed_m;
  logic       bit_m, valid_m, pulse_m;
  logic [7:0] lfsr_m, data_m, plen_m;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned pulses;
  int unsigned zeros;

  logic [7:0] seq [0:17];

  m_sequence_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
    .bit_out(bit_out), .lfsr_state(lfsr_state), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready),
    .period_pulse(period_pulse), .period_len(period_len)
  );

  m_sequence_gen #(.TAPS(8'hB8)) dut_ml (
    .clk(clk), .rst_n(rst_n), .en(en_m), .load(load_m), .seed_in(seed_m),
    .bit_out(bit_m), .lfsr_state(lfsr_m), .word_data(data_m),
    .word_valid(valid_m), .word_ready(ready_m),
    .period_pulse(pulse_m), .period_len(plen_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    seq = '{8'h01, 8'h02, 8'h04, 8'h09, 8'h13, 8'h27, 8'h4F, 8'h9E, 8'h3C,
            8'h79, 8'hF2, 8'hE4, 8'hC8, 8'h90, 8'h20, 8'h40, 8'h80, 8'h01};
    rst_n = 1'b0; en = 1'b0; load = 1'b0; seed_in = '0; word_ready = 1'b1;
    en_m = 1'b0; load_m = 1'b0; seed_m = '0; ready_m = 1'b1;

    #12;
    check("rst_state", lfsr_state, 8'h01);
    check("rst_bit", bit_out, 1'b0);
    check("rst_valid", word_valid, 1'b0);
    check("rst_data", word_data, 8'h00);
    check("rst_pulse", period_pulse, 1'b0);
    check("rst_plen", period_len, 8'h00);

    rst_n = 1'b1;
    en    = 1'b1;

    // first word: eight steps from 0x01
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("seq%0d", k), lfsr_state, seq[k]);
      check($sformatf("bit%0d", k), bit_out, seq[k][7]);
      if (k >= 7) check($sformatf("valid%0d", k), word_valid, (k == 8));
    end
    check("word1", word_data, 8'h01);

    // backpressure: seven more steps, then stall
    word_ready = 1'b0;
    for (int k = 9; k <= 15; k++) begin
      tick();
      check($sformatf("seq%0d", k), lfsr_state, seq[k]);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_state", lfsr_state, 8'h40);
      check("stall_valid", word_valid, 1'b1);
      check("stall_data", word_data, 8'h01);
    end

    // one-cycle drain: consume and refill in the same cycle
    word_ready = 1'b1;
    tick();
    check("drain_state", lfsr_state, 8'h80);
    check("drain_valid", word_valid, 1'b1);
    check("word2", word_data, 8'h3C);
    word_ready = 1'b0;

    // 17th step returns to the start state
    tick();
    check("wrap_state", lfsr_state, 8'h01);
    check("wrap_pulse", period_pulse, 1'b1);
    check("wrap_plen", period_len, 8'h11);
    tick();
    check("post_pulse", period_pulse, 1'b0);
    check("post_state", lfsr_state, 8'h02);
    check("held_data", word_data, 8'h3C);
    check("held_valid", word_valid, 1'b1);

    // zero seed loads the default seed and discards the pending word
    load = 1'b1; seed_in = 8'h00;
    tick();
    check("ld0_state", lfsr_state, 8'h01);
    check("ld0_valid", word_valid, 1'b0);
    check("ld0_plen", period_len, 8'h11);
    load = 1'b0; word_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k >= 7) check($sformatf("ld0_valid%0d", k), word_valid, (k == 8));
    end
    check("ld0_word", word_data, 8'h01);

    // load while a word is offered and ready is high: word is dropped
    load = 1'b1; seed_in = 8'hA5;
    tick();
    check("ldA5_state", lfsr_state, 8'hA5);
    check("ldA5_valid", word_valid, 1'b0);
    load = 1'b0;
    tick(); check("a5_s1", lfsr_state, 8'h4A);
    tick(); check("a5_s2", lfsr_state, 8'h95);
    tick(); check("a5_s3", lfsr_state, 8'h2B);

    // enable low freezes everything
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_state", lfsr_state, 8'h2B);
      check("hold_valid", word_valid, 1'b0);
      check("hold_pulse", period_pulse, 1'b0);
    end
    en = 1'b1;
    tick();
    check("resume_state", lfsr_state, 8'h57);

    // asynchronous reset mid-word, checked before the next clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_state", lfsr_state, 8'h01);
    check("arst_valid", word_valid, 1'b0);
    check("arst_data", word_data, 8'h00);
    check("arst_plen", period_len, 8'h00);
    check("arst_pulse", period_pulse, 1'b0);

    // maximal-length instance: 255-step period from reset seed
    #2;
    rst_n = 1'b1; en = 1'b0;
    en_m = 1'b1; ready_m = 1'b1;
    pulses = 0; zeros = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (lfsr_m == 8'h00) zeros++;
      if (pulse_m) pulses++;
    end
    check("ml_state", lfsr_m, 8'h01);
    check("ml_pulse", pulse_m, 1'b1);
    check("ml_pulses", pulses, 1);
    check("ml_plen", plen_m, 8'hFF);
    check("ml_zero", zeros, 0);

    // pending word, then load 0xA5 with ready high
    ready_m = 1'b0;
    tick();
    check("ml_pend", valid_m, 1'b1);
    load_m = 1'b1; seed_m = 8'hA5; ready_m = 1'b1;
    tick();
    check("ml_ld_state", lfsr_m, 8'hA5);
    check("ml_ld_valid", valid_m, 1'b0);
    check("ml_ld_plen", plen_m, 8'hFF);
    load_m = 1'b0;
    pulses = 0; zeros = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (lfsr_m == 8'h00) zeros++;
      if (pulse_m) pulses++;
    end
    check("ml_a5_state", lfsr_m, 8'hA5);
    check("ml_a5_pulse", pulse_m, 1'b1);
    check("ml_a5_pulses", pulses, 1);
    check("ml_a5_plen", plen_m, 8'hFF);
    check("ml_a5_zero", zeros, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
